// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-setting controller: FSM encoding, edit_mode
// codes, BCD time limits and default timing parameters.
package clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_T_HR     = 3'd1,
    S_T_MIN    = 3'd2,
    S_COMMIT_T = 3'd3,
    S_A_HR     = 3'd4,
    S_A_MIN    = 3'd5,
    S_COMMIT_A = 3'd6,
    S_SNOOZE   = 3'd7
  } state_t;

  localparam logic [2:0] EM_IDLE  = 3'd0;
  localparam logic [2:0] EM_T_HR  = 3'd1;
  localparam logic [2:0] EM_T_MIN = 3'd2;
  localparam logic [2:0] EM_A_HR  = 3'd3;
  localparam logic [2:0] EM_A_MIN = 3'd4;

  localparam int HOUR_MAX     = 23;
  localparam int MIN_MAX      = 59;
  localparam int MIN_PER_HOUR = MIN_MAX + 1;

  localparam int TIMEOUT_DEF    = 30;
  localparam int SNOOZE_MIN_DEF = 5;
  localparam int SNOOZE_MAX_DEF = 3;

  typedef struct packed {
    logic [1:0] h_msb;
    logic [3:0] h_lsb;
    logic [3:0] m_msb;
    logic [3:0] m_lsb;
  } hhmm_t;

  function automatic logic [6:0] bcd2bin(input logic [3:0] msb, input logic [3:0] lsb);
    return 7'(msb) * 7'd10 + 7'(lsb);
  endfunction

  function automatic logic [2:0] mode_of(input state_t s);
    case (s)
      S_T_HR:  return EM_T_HR;
      S_T_MIN: return EM_T_MIN;
      S_A_HR:  return EM_A_HR;
      S_A_MIN: return EM_A_MIN;
      default: return EM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// Button/time bus between the user-interface front end and the alarm-setting
// controller; slave is the controller side.
interface alarm_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_ok;
  logic       btn_snooze;
  logic       alarm;
  logic [1:0] cur_hour_msb;
  logic [3:0] cur_hour_lsb;
  logic [3:0] cur_min_msb;
  logic [3:0] cur_min_lsb;
  logic [1:0] inhour_msb;
  logic [3:0] inhour_lsb;
  logic [3:0] inmin_msb;
  logic [3:0] inmin_lsb;
  logic       set_time;
  logic       set_alarm;
  logic       alm_off;
  logic       alm_on;
  logic [2:0] edit_mode;

  modport slave (
    input  btn_mode, btn_inc, btn_ok, btn_snooze, alarm,
           cur_hour_msb, cur_hour_lsb, cur_min_msb, cur_min_lsb,
    output inhour_msb, inhour_lsb, inmin_msb, inmin_lsb,
           set_time, set_alarm, alm_off, alm_on, edit_mode
  );

  modport master (
    output btn_mode, btn_inc, btn_ok, btn_snooze, alarm,
           cur_hour_msb, cur_hour_lsb, cur_min_msb, cur_min_lsb,
    input  inhour_msb, inhour_lsb, inmin_msb, inmin_lsb,
           set_time, set_alarm, alm_off, alm_on, edit_mode
  );
endinterface

// File: rtl/bcd_hhmm_add.sv
// Combinational BCD hh:mm + N minutes. hold_hour keeps the hour fixed so the
// minute field wraps on its own; adding 60 with hold_hour=0 steps the hour only.
module bcd_hhmm_add
  import clock_pkg::*;
(
  input  hhmm_t      a,
  input  logic [6:0] add_min,
  input  logic       hold_hour,
  output hhmm_t      sum
);

  logic [6:0] hr;
  logic [6:0] mn;
  logic [6:0] mt;
  logic [6:0] mo;
  logic [6:0] ho;
  logic       carry;

  always_comb begin
    hr    = bcd2bin({2'b00, a.h_msb}, a.h_lsb);
    mn    = bcd2bin(a.m_msb, a.m_lsb);
    mt    = mn + add_min;
    carry = (mt >= 7'(MIN_PER_HOUR));
    mo    = carry ? mt - 7'(MIN_PER_HOUR) : mt;
    ho    = hr;
    if (carry && !hold_hour)
      ho = (hr == 7'(HOUR_MAX)) ? 7'd0 : hr + 7'd1;
    sum.h_msb = 2'(ho / 7'd10);
    sum.h_lsb = 4'(ho % 7'd10);
    sum.m_msb = 4'(mo / 7'd10);
    sum.m_lsb = 4'(mo % 7'd10);
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm clock setting controller: time/alarm edit FSM, alarm enable, snooze
// and dismiss handling, with an inactivity timeout on edits.
module alarm_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int SNOOZE_MIN = SNOOZE_MIN_DEF,
  parameter int SNOOZE_MAX = SNOOZE_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  alarm_set_ctrl_if.slave  bus
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SNZ_W = $clog2(SNOOZE_MAX + 1);

  state_t           state;
  hhmm_t            edit_q;
  hhmm_t            alarm_q;
  hhmm_t            cur_t;
  hhmm_t            add_a;
  hhmm_t            add_sum;
  logic [6:0]       add_n;
  logic             add_hold;
  logic [TO_W-1:0]  to_cnt;
  logic [SNZ_W-1:0] snz_cnt;
  logic [2:0]       edit_mode_q;
  logic             set_time_q;
  logic             set_alarm_q;
  logic             alm_off_q;
  logic             alm_on_q;
  logic             b_mode;
  logic             b_ok;
  logic             b_inc;
  logic             b_snz;
  logic             any_btn;
  logic             in_edit;
  logic             timed_out;

  assign cur_t = {bus.cur_hour_msb, bus.cur_hour_lsb, bus.cur_min_msb, bus.cur_min_lsb};

  // Only the highest-priority button is serviced in a cycle.
  assign b_mode  = bus.btn_mode;
  assign b_ok    = bus.btn_ok & ~bus.btn_mode;
  assign b_inc   = bus.btn_inc & ~bus.btn_mode & ~bus.btn_ok;
  assign b_snz   = bus.btn_snooze & ~bus.btn_mode & ~bus.btn_ok & ~bus.btn_inc;
  assign any_btn = bus.btn_mode | bus.btn_ok | bus.btn_inc | bus.btn_snooze;

  assign in_edit   = (state == S_T_HR) || (state == S_T_MIN) ||
                     (state == S_A_HR) || (state == S_A_MIN);
  assign timed_out = !any_btn && (to_cnt == TO_W'(TIMEOUT - 1));

  // One adder serves snooze (from the stored alarm) and both increment kinds.
  always_comb begin
    add_a    = edit_q;
    add_n    = 7'd1;
    add_hold = 1'b1;
    case (state)
      S_IDLE: begin
        add_a    = alarm_q;
        add_n    = 7'(SNOOZE_MIN);
        add_hold = 1'b0;
      end
      S_T_HR, S_A_HR: begin
        add_n    = 7'(MIN_PER_HOUR);
        add_hold = 1'b0;
      end
      default: ;
    endcase
  end

  bcd_hhmm_add u_add (
    .a         (add_a),
    .add_min   (add_n),
    .hold_hour (add_hold),
    .sum       (add_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      edit_mode_q <= EM_IDLE;
      edit_q      <= '0;
      alarm_q     <= '0;
      to_cnt      <= '0;
      snz_cnt     <= '0;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      alm_off_q   <= 1'b0;
      alm_on_q    <= 1'b0;
    end else begin
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      alm_off_q   <= 1'b0;
      to_cnt      <= (in_edit && !any_btn) ? to_cnt + TO_W'(1) : '0;
      case (state)
        S_IDLE: begin
          if (b_mode) begin
            state       <= S_T_HR;
            edit_mode_q <= mode_of(S_T_HR);
            edit_q      <= cur_t;
          end else if (b_ok && bus.alarm) begin
            alm_off_q <= 1'b1;
            snz_cnt   <= '0;
          end else if (b_snz && bus.alarm) begin
            alm_off_q <= 1'b1;
            if (snz_cnt < SNZ_W'(SNOOZE_MAX)) begin
              alarm_q <= add_sum;
              edit_q  <= add_sum;
              snz_cnt <= snz_cnt + SNZ_W'(1);
              state   <= S_SNOOZE;
            end else begin
              snz_cnt <= '0;
            end
          end else if (b_snz) begin
            alm_on_q  <= ~alm_on_q;
            alm_off_q <= alm_on_q;
          end
        end
        S_T_HR, S_T_MIN: begin
          if (b_mode) begin
            state       <= S_A_HR;
            edit_mode_q <= mode_of(S_A_HR);
            edit_q      <= alarm_q;
          end else if (b_ok && state == S_T_HR) begin
            state       <= S_T_MIN;
            edit_mode_q <= mode_of(S_T_MIN);
          end else if (b_ok) begin
            state       <= S_COMMIT_T;
            edit_mode_q <= EM_IDLE;
            set_time_q  <= 1'b1;
          end else if (b_inc) begin
            edit_q <= add_sum;
          end else if (timed_out) begin
            state       <= S_IDLE;
            edit_mode_q <= EM_IDLE;
            to_cnt      <= '0;
          end
        end
        S_A_HR, S_A_MIN: begin
          if (b_mode) begin
            state       <= S_IDLE;
            edit_mode_q <= EM_IDLE;
          end else if (b_ok && state == S_A_HR) begin
            state       <= S_A_MIN;
            edit_mode_q <= mode_of(S_A_MIN);
          end else if (b_ok) begin
            state       <= S_COMMIT_A;
            edit_mode_q <= EM_IDLE;
            set_alarm_q <= 1'b1;
            alarm_q     <= edit_q;
            alm_on_q    <= 1'b1;
            snz_cnt     <= '0;
          end else if (b_inc) begin
            edit_q <= add_sum;
          end else if (timed_out) begin
            state       <= S_IDLE;
            edit_mode_q <= EM_IDLE;
            to_cnt      <= '0;
          end
        end
        S_SNOOZE: begin
          state       <= S_COMMIT_A;
          set_alarm_q <= 1'b1;
          alm_on_q    <= 1'b1;
        end
        S_COMMIT_T, S_COMMIT_A: begin
          state       <= S_IDLE;
          edit_mode_q <= EM_IDLE;
        end
      endcase
    end
  end

  assign bus.inhour_msb = edit_q.h_msb;
  assign bus.inhour_lsb = edit_q.h_lsb;
  assign bus.inmin_msb  = edit_q.m_msb;
  assign bus.inmin_lsb  = edit_q.m_lsb;
  assign bus.set_time   = set_time_q;
  assign bus.set_alarm  = set_alarm_q;
  assign bus.alm_off    = alm_off_q;
  assign bus.alm_on     = alm_on_q;
  assign bus.edit_mode  = edit_mode_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: pulses are checked by a scoreboard
// monitor, levels (edit_mode, in*, alm_on) by direct checks.
module tb_alarm_set_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  alarm_set_ctrl_if aif();

  alarm_set_ctrl #(
    .TIMEOUT    (30),
    .SNOOZE_MIN (5),
    .SNOOZE_MAX (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (aif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sa;
    logic        ao;
    logic        chk_val;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [3:0] B_MODE = 4'b1000;
  localparam logic [3:0] B_OK   = 4'b0100;
  localparam logic [3:0] B_INC  = 4'b0010;
  localparam logic [3:0] B_SNZ  = 4'b0001;

  logic [15:0] in_val;
  assign in_val = {2'b00, aif.inhour_msb, aif.inhour_lsb, aif.inmin_msb, aif.inmin_lsb};

  // Scoreboard monitor: every pulse cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (aif.set_time || aif.set_alarm || aif.alm_off) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse got st=%b sa=%b ao=%b in=%h, required no pulse",
                 aif.set_time, aif.set_alarm, aif.alm_off, in_val);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.st !== aif.set_time || got_e.sa !== aif.set_alarm ||
            got_e.ao !== aif.alm_off || (got_e.chk_val && in_val !== got_e.val)) begin
          n_err++;
          $display("FAIL pulse got st=%b sa=%b ao=%b in=%h, required st=%b sa=%b ao=%b in=%h",
                   aif.set_time, aif.set_alarm, aif.alm_off, in_val,
                   got_e.st, got_e.sa, got_e.ao, got_e.val);
        end
      end
    end
  end

  task automatic expect_pulse(input logic st, input logic sa, input logic ao,
                              input logic cv, input logic [15:0] v);
    exp_t e;
    e.st = st; e.sa = sa; e.ao = ao; e.chk_val = cv; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    {aif.btn_mode, aif.btn_ok, aif.btn_inc, aif.btn_snooze} = b;
    tick(1);
    {aif.btn_mode, aif.btn_ok, aif.btn_inc, aif.btn_snooze} = 4'b0000;
  endtask

  task automatic press_n(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {aif.btn_mode, aif.btn_ok, aif.btn_inc, aif.btn_snooze} = 4'b0000;
    aif.alarm        = 1'b0;
    aif.cur_hour_msb = 2'd1;
    aif.cur_hour_lsb = 4'd0;
    aif.cur_min_msb  = 4'd1;
    aif.cur_min_lsb  = 4'd4;

    #12;
    chk("rst_in", in_val, 16'h0000);
    chk("rst_mode", 16'(aif.edit_mode), 16'd0);
    chk("rst_outs", 16'({aif.set_time, aif.set_alarm, aif.alm_off, aif.alm_on}), 16'd0);
    reset = 1'b1;
    tick(1);

    // Time set 10:14 -> 13:16
    press(B_MODE);
    chk("t_hr_mode", 16'(aif.edit_mode), 16'd1);
    chk("t_load_cur", in_val, 16'h1014);
    press_n(B_INC, 3);
    chk("t_hr_inc", in_val, 16'h1314);
    press(B_OK);
    chk("t_min_mode", 16'(aif.edit_mode), 16'd2);
    press_n(B_INC, 2);
    chk("t_min_inc", in_val, 16'h1316);
    expect_pulse(1'b1, 1'b0, 1'b0, 1'b1, 16'h1316);
    press(B_OK);
    chk("commit_t_mode", 16'(aif.edit_mode), 16'd0);
    tick(1);
    chk("after_commit_t_mode", 16'(aif.edit_mode), 16'd0);

    // Store alarm 23:59 via the alarm edit path
    press(B_MODE);
    press(B_MODE);
    chk("a_hr_mode", 16'(aif.edit_mode), 16'd3);
    chk("a_load_stored", in_val, 16'h0000);
    press_n(B_INC, 23);
    chk("a_hr_23", in_val, 16'h2300);
    press(B_OK);
    chk("a_min_mode", 16'(aif.edit_mode), 16'd4);
    press_n(B_INC, 59);
    chk("a_min_59", in_val, 16'h2359);
    expect_pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h2359);
    press(B_OK);
    chk("alm_on_set", 16'(aif.alm_on), 16'd1);
    tick(1);

    // Edit from 23:59: hour wrap, then minute wrap without hour carry
    press(B_MODE);
    press(B_MODE);
    chk("a_reload_2359", in_val, 16'h2359);
    press(B_INC);
    chk("hour_wrap", in_val, 16'h0059);
    press(B_OK);
    press(B_INC);
    chk("min_wrap", in_val, 16'h0000);
    expect_pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    press(B_OK);
    tick(1);

    // Store 23:58, then snooze across midnight
    press(B_MODE);
    press(B_MODE);
    press_n(B_INC, 23);
    press(B_OK);
    press_n(B_INC, 58);
    expect_pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h2358);
    press(B_OK);
    tick(1);
    aif.alarm = 1'b1;
    expect_pulse(1'b0, 1'b0, 1'b1, 1'b1, 16'h0003);
    expect_pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h0003);
    press(B_SNZ);
    chk("snooze_mode", 16'(aif.edit_mode), 16'd0);
    tick(3);

    // Dismiss clears count; then snooze limit
    expect_pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    press(B_OK);
    chk("dismiss_alm_on", 16'(aif.alm_on), 16'd1);
    tick(1);
    for (int i = 1; i <= 3; i++) begin
      logic [15:0] v;
      v = (i == 1) ? 16'h0008 : (i == 2) ? 16'h0013 : 16'h0018;
      expect_pulse(1'b0, 1'b0, 1'b1, 1'b1, v);
      expect_pulse(1'b0, 1'b1, 1'b0, 1'b1, v);
      press(B_SNZ);
      tick(3);
    end
    expect_pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    press(B_SNZ);
    tick(2);
    chk("limit_keeps_edit", in_val, 16'h0018);
    expect_pulse(1'b0, 1'b0, 1'b1, 1'b1, 16'h0023);
    expect_pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h0023);
    press(B_SNZ);
    tick(3);

    // ok outranks snooze: dismiss only
    expect_pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    press(B_OK | B_SNZ);
    tick(3);
    aif.alarm = 1'b0;

    // alm_on toggle with no alarm ringing
    expect_pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    press(B_SNZ);
    chk("toggle_off", 16'(aif.alm_on), 16'd0);
    press(B_SNZ);
    chk("toggle_on", 16'(aif.alm_on), 16'd1);
    tick(2);

    // Edit timeout in T_MIN
    press(B_MODE);
    press(B_OK);
    tick(29);
    chk("timeout_29", 16'(aif.edit_mode), 16'd2);
    tick(1);
    chk("timeout_30", 16'(aif.edit_mode), 16'd0);

    // Asynchronous reset mid-edit
    press(B_MODE);
    press(B_OK);
    press(B_INC);
    chk("pre_rst_in", in_val, 16'h1015);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_in", in_val, 16'h0000);
    chk("midrst_mode", 16'(aif.edit_mode), 16'd0);
    chk("midrst_outs", 16'({aif.set_time, aif.set_alarm, aif.alm_off, aif.alm_on}), 16'd0);
    #3;
    reset = 1'b1;
    tick(1);
    press(B_MODE);
    press(B_MODE);
    chk("rst_alarm_clr", in_val, 16'h0000);

    // Abort from alarm edit, and mode beating ok in T_HR
    press(B_MODE);
    chk("abort_mode", 16'(aif.edit_mode), 16'd0);
    press(B_MODE);
    press(B_MODE | B_OK);
    chk("mode_over_ok", 16'(aif.edit_mode), 16'd3);
    press(B_MODE);
    chk("abort2_mode", 16'(aif.edit_mode), 16'd0);
    tick(3);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got=%0d pending required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alarm_set_ctrl.md
ALARM_SET_CTRL -- requirements
Module: alarm_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, meaning idle clk cycles (seconds) before an edit is abandoned.
REQ-002 SHALL have parameter SNOOZE_MIN, default 5, meaning minutes added per snooze.
REQ-003 SHALL have parameter SNOOZE_MAX, default 3, meaning snoozes allowed per alarm event.
REQ-004 SHALL have ports: clk  in  1  single clock, 1 Hz timebase shared with the alarm clock datapath.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: btn_mode, btn_inc, btn_ok, btn_snooze  in  1 each  debounced, synchronous, one-cycle button pulses.
REQ-007 SHALL have ports: alarm  in  1  ringing indication from the clock datapath.
REQ-008 SHALL have ports: cur_hour_msb[1:0], cur_hour_lsb[3:0], cur_min_msb[3:0], cur_min_lsb[3:0]  in  current BCD time.
REQ-009 SHALL have ports: inhour_msb[1:0], inhour_lsb[3:0], inmin_msb[3:0], inmin_lsb[3:0]  out  BCD edit/commit value.
REQ-010 SHALL have ports: set_time, set_alarm, alm_off  out  1 each  one-cycle pulses; alm_on  out  1  alarm-enable level.
REQ-011 SHALL have ports: edit_mode  out  3  0 idle, 1 time-hour, 2 time-minute, 3 alarm-hour, 4 alarm-minute.

Function
REQ-012 SHALL implement states IDLE, T_HR, T_MIN, COMMIT_T, A_HR, A_MIN, COMMIT_A, SNOOZE.
REQ-013 SHALL service only the highest-priority button per cycle: mode > ok > inc > snooze; lower ones are dropped.
REQ-014 IDLE + btn_mode SHALL go to T_HR, loading the edit register from cur_* at the same edge.
REQ-015 T_HR/T_MIN + btn_mode SHALL go to A_HR, loading the edit register from the stored alarm time, without emitting set_time.
REQ-016 A_HR/A_MIN + btn_mode SHALL return to IDLE with no pulse emitted (abort).
REQ-017 btn_inc in T_HR/A_HR SHALL increment hour 00..23 with wrap 23->00; in T_MIN/A_MIN it SHALL increment minute 00..59 with wrap 59->00, hour unchanged.
REQ-018 btn_ok in T_HR->T_MIN, in T_MIN->COMMIT_T, in A_HR->A_MIN, in A_MIN->COMMIT_A.
REQ-019 COMMIT_T SHALL last exactly one cycle with set_time=1, then go to IDLE.
REQ-020 COMMIT_A SHALL last one cycle with set_alarm=1, copy the edit value into the stored alarm time, set alm_on=1, clear the snooze count, then go to IDLE.
REQ-021 in* SHALL always equal the edit register; it SHALL be valid in every cycle where set_time or set_alarm is high.
REQ-022 The timeout counter SHALL reset on any button pulse; TIMEOUT consecutive cycles with no button in an edit state SHALL return to IDLE with no pulse.
REQ-023 IDLE, alarm=1, btn_ok SHALL emit alm_off for one cycle, clear the snooze count, and keep alm_on=1.
REQ-024 IDLE, alarm=1, btn_snooze, snooze count < SNOOZE_MAX: at edge k, stored alarm time += SNOOZE_MIN with minute carry into hour and 23:5x->00:0x wrap, edit <= new time, count++.
REQ-025 In the same case, alm_off=1 in cycle k+1 (SNOOZE), then set_alarm=1 in cycle k+2 (COMMIT_A, count not cleared), then IDLE.
REQ-026 When snooze count == SNOOZE_MAX, btn_snooze SHALL act as btn_ok (dismiss).
REQ-027 IDLE, alarm=0, btn_snooze SHALL toggle alm_on; alm_on 1->0 SHALL also emit alm_off for one cycle.
REQ-028 edit_mode SHALL be registered, reflect the current state, and read 0 in COMMIT_*/SNOOZE.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, all outputs 0, stored alarm 00:00, edit 00:00, snooze count 0, timeout counter 0, including mid-edit or mid-snooze.

Structure
REQ-030 A shared package clock_pkg SHALL hold the state encoding, edit_mode codes, BCD limits (23, 59), and the TIMEOUT/SNOOZE defaults.
REQ-031 One combinational sub-module bcd_hhmm_add SHALL add N minutes to a BCD hh:mm with carry/wrap; it is used for increment and snooze.

Verification
REQ-032 Reset; mode, inc x3, ok, inc x2, ok with cur=10:14 -> set_time one cycle, in*=13:16, edit_mode=0 next cycle.
REQ-033 Alarm edit from 23:59: inc on hour -> 00:59; ok, inc -> 00:00; ok -> set_alarm pulse, alm_on=1.
REQ-034 Stored alarm 23:58, alarm=1, snooze -> alm_off at k+1, set_alarm at k+2 with in*=00:03.
REQ-035 Four snoozes in one event -> three set_alarm pulses; fourth yields alm_off only, count cleared.
REQ-036 Enter T_MIN, idle 30 cycles -> IDLE, no set_time; reset asserted in T_MIN -> all outputs 0 immediately.
REQ-037 btn_mode and btn_ok in the same cycle in T_HR -> A_HR, no set_time.
